// File: rtl/instr_encoder_pkg.sv
// Shared types, opcode/ALU constants and the combinational RV32I encode function
// used by the instruction encoder.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        KIND_R       = 3'd0,
        KIND_I       = 3'd1,
        KIND_LOAD    = 3'd2,
        KIND_STORE   = 3'd3,
        KIND_BRANCH  = 3'd4,
        KIND_JAL     = 3'd5,
        KIND_JALR    = 3'd6,
        KIND_ILLEGAL = 3'd7
    } kind_e;

    // Same values as the control unit's ALUOp codes.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        kind_e       kind;
        logic [3:0]  aluop;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    function automatic logic [2:0] alu_funct3(input logic [3:0] op);
        case (op)
            ALU_ADD, ALU_SUB: return 3'b000;
            ALU_SLL:          return 3'b001;
            ALU_SLT:          return 3'b010;
            ALU_SLTU:         return 3'b011;
            ALU_XOR:          return 3'b100;
            ALU_SRL, ALU_SRA: return 3'b101;
            ALU_OR:           return 3'b110;
            default:          return 3'b111;
        endcase
    endfunction

    function automatic logic fits_i(input logic signed [31:0] v);
        return (v >= -2048) && (v <= 2047);
    endfunction

    function automatic enc_t encode(input req_t r);
        enc_t              e;
        logic signed [31:0] imm;
        logic [6:0]        f7;
        logic              is_shift;
        imm      = $signed(r.imm);
        is_shift = r.aluop inside {ALU_SLL, ALU_SRL, ALU_SRA};
        f7       = (r.aluop == ALU_SUB || r.aluop == ALU_SRA) ? 7'b0100000 : 7'b0000000;
        // NOTE: every output gets a default before the case so no path leaves it unassigned.
        e.legal  = 1'b0;
        e.word   = '0;
        case (r.kind)
            KIND_R: begin
                e.legal = r.aluop <= ALU_SLTU;
                e.word  = {f7, r.rs2, r.rs1, alu_funct3(r.aluop), r.rd, OP_R};
            end
            KIND_I: begin
                e.legal = (r.aluop <= ALU_SLTU) && (r.aluop != ALU_SUB) &&
                          (is_shift ? (imm >= 0 && imm <= 31) : fits_i(imm));
                e.word  = is_shift ? {f7, r.imm[4:0], r.rs1, alu_funct3(r.aluop), r.rd, OP_I}
                                   : {r.imm[11:0], r.rs1, alu_funct3(r.aluop), r.rd, OP_I};
            end
            KIND_LOAD: begin
                e.legal = (r.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && fits_i(imm);
                e.word  = {r.imm[11:0], r.rs1, r.f3, r.rd, OP_LOAD};
            end
            KIND_STORE: begin
                e.legal = (r.f3 <= 3'd2) && fits_i(imm);
                e.word  = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], OP_STORE};
            end
            KIND_BRANCH: begin
                e.legal = !(r.f3 inside {3'd2, 3'd3}) && (imm >= -4096) && (imm <= 4094) && !r.imm[0];
                e.word  = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], OP_BRANCH};
            end
            KIND_JAL: begin
                e.legal = (imm >= -1048576) && (imm <= 1048574) && !r.imm[0];
                e.word  = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, OP_JAL};
            end
            KIND_JALR: begin
                e.legal = fits_i(imm);
                e.word  = {r.imm[11:0], r.rs1, 3'b000, r.rd, OP_JALR};
            end
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO with wrap-bit pointers; DEPTH must be a power of two, at least 2.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: storage is left unreset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes abstract instruction requests to RV32I words, queues them, and streams
// them to instruction memory at auto-incrementing word addresses.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int            DEPTH     = 4,
    parameter int            AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_kind,
    input  logic [3:0]    in_aluop,
    input  logic [2:0]    in_f3,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    output logic          wr_en,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          err,
    output logic [15:0]   count
);
    req_t        req;
    enc_t        enc;
    logic        accept;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [31:0] head;

    assign req = '{kind: kind_e'(in_kind), aluop: in_aluop, f3: in_f3,
                   rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
    assign enc = encode(req);

    assign in_ready = !rst && !full;
    assign accept   = in_valid && in_ready;
    // Rejected requests still complete the handshake; they only raise err.
    assign push     = accept && enc.legal;
    assign wr_en    = !empty;
    assign pop      = wr_en && wr_ready;
    assign wr_data  = empty ? 32'd0 : head;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (enc.word),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr <= BASE_ADDR;
            err     <= 1'b0;
            count   <= '0;
        end else begin
            if (pop) begin
                wr_addr <= wr_addr + AW'(4);
                if (count != 16'hFFFF) count <= count + 16'd1;
            end
            if (accept && !enc.legal) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench: directed encodings, backpressure, illegal requests, address
// wrap, mid-stream reset, and randomized traffic against a cycle-level queue model.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, wr_en, wr_ready, err;
    logic [2:0]  in_kind, in_f3;
    logic [3:0]  in_aluop;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, wr_addr, wr_data;
    logic [15:0] count;

    logic        w_valid, w_in_ready, w_en, w_ready, w_err;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic [15:0] w_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_addr = BASE;
    logic [15:0] exp_count = '0;
    bit          exp_err = 1'b0;
    bit          rnd_done;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .AW(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_aluop(in_aluop), .in_f3(in_f3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .wr_en(wr_en),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .err(err), .count(count)
    );

    instr_encoder #(.DEPTH(DEPTH), .AW(4), .BASE_ADDR(4'd12)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_in_ready),
        .in_kind(in_kind), .in_aluop(in_aluop), .in_f3(in_f3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .wr_en(w_en),
        .wr_ready(w_ready), .wr_addr(w_addr), .wr_data(w_data), .err(w_err), .count(w_count)
    );

    function automatic bit [31:0] fields(input int unsigned f7, rs2, rs1, f3, rd, op);
        return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    endfunction

    // Reference encoder: builds words field by field from the ISA layout.
    function automatic void ref_encode(input int k, input int a, input int f, input int rd,
                                       input int rs1, input int rs2, input int imm,
                                       output bit ok, output bit [31:0] w);
        int alu_f3 [10] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3};
        bit shift;
        bit in12;
        shift = (a == 5 || a == 6 || a == 7);
        in12  = (imm >= -2048 && imm <= 2047);
        ok = 1'b0;
        w  = 32'd0;
        case (k)
            0: begin
                ok = (a <= 9);
                if (ok) w = fields((a == 1 || a == 7) ? 32 : 0, rs2, rs1, alu_f3[a], rd, 'h33);
            end
            1: begin
                ok = (a <= 9) && (a != 1) && (shift ? (imm >= 0 && imm <= 31) : in12);
                if (a <= 9) begin
                    if (shift) w = fields((a == 7) ? 32 : 0, imm & 31, rs1, alu_f3[a], rd, 'h13);
                    else       w = fields((imm >> 5) & 127, imm & 31, rs1, alu_f3[a], rd, 'h13);
                end
            end
            2: begin
                ok = (f == 0 || f == 1 || f == 2 || f == 4 || f == 5) && in12;
                w  = fields((imm >> 5) & 127, imm & 31, rs1, f, rd, 'h03);
            end
            3: begin
                ok = (f <= 2) && in12;
                w  = fields((imm >> 5) & 127, rs2, rs1, f, imm & 31, 'h23);
            end
            4: begin
                ok = (f != 2 && f != 3) && imm >= -4096 && imm <= 4094 && (imm & 1) == 0;
                w  = fields(((imm >> 12) & 1) * 64 + ((imm >> 5) & 63), rs2, rs1, f,
                            ((imm >> 1) & 15) * 2 + ((imm >> 11) & 1), 'h63);
            end
            5: begin
                ok = imm >= -1048576 && imm <= 1048574 && (imm & 1) == 0;
                w  = ((((imm >> 20) & 1) << 19 | ((imm >> 1) & 1023) << 9 |
                       ((imm >> 11) & 1) << 8 | ((imm >> 12) & 255)) << 12) | (rd << 7) | 'h6F;
            end
            6: begin
                ok = in12;
                w  = fields((imm >> 5) & 127, imm & 31, rs1, 0, rd, 'h67);
            end
            default: ok = 1'b0;
        endcase
    endfunction

    // Cycle-level model: queue of expected words, address, count and sticky error.
    task automatic monitor();
        bit          ok;
        bit          had_room;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL mon_ready_in_reset got=%b want=0", in_ready);
                end
                exp_q.delete();
                exp_addr  = BASE;
                exp_count = '0;
                exp_err   = 1'b0;
            end else begin
                n_cmp++;
                if (in_ready !== (exp_q.size() < DEPTH) || wr_en !== (exp_q.size() != 0) ||
                    err !== exp_err || count !== exp_count) begin
                    n_bad++;
                    $display("FAIL mon_state t=%0t got ready=%b en=%b err=%b cnt=%0d want ready=%b en=%b err=%b cnt=%0d",
                             $time, in_ready, wr_en, err, count, exp_q.size() < DEPTH,
                             exp_q.size() != 0, exp_err, exp_count);
                end
                if (exp_q.size() != 0) begin
                    n_cmp++;
                    if (wr_data !== exp_q[0] || wr_addr !== exp_addr) begin
                        n_bad++;
                        $display("FAIL mon_write t=%0t got data=%h addr=%h want data=%h addr=%h",
                                 $time, wr_data, wr_addr, exp_q[0], exp_addr);
                    end
                end
                had_room = exp_q.size() < DEPTH;
                if (exp_q.size() != 0 && wr_ready === 1'b1) begin
                    void'(exp_q.pop_front());
                    exp_addr += 32'd4;
                    if (exp_count != 16'hFFFF) exp_count++;
                end
                if (in_valid === 1'b1 && had_room) begin
                    ref_encode(int'(in_kind), int'(in_aluop), int'(in_f3), int'(in_rd),
                               int'(in_rs1), int'(in_rs2), int'(in_imm), ok, w);
                    if (ok) exp_q.push_back(w);
                    else    exp_err = 1'b1;
                end
            end
        end
    endtask

    // All tasks start and end one time unit after a rising edge.
    task automatic send(input logic [2:0] k, input logic [3:0] a, input logic [2:0] f,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
        int waited = 0;
        in_kind = k; in_aluop = a; in_f3 = f; in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout got in_ready=%b want 1 within 200 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        wr_ready = 1'b1;
        @(negedge clk);
        while (wr_en !== 1'b0 && c < 100) begin
            c++;
            @(negedge clk);
        end
        if (wr_en !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout got wr_en=%b want 0", wr_en);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (wr_en !== 1'b0 || wr_addr !== BASE || wr_data !== 32'd0 || err !== 1'b0 ||
            count !== 16'd0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_values got en=%b addr=%h data=%h err=%b cnt=%0d rdy=%b want 0 %h 0 0 0 1",
                     wr_en, wr_addr, wr_data, err, count, in_ready, BASE);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  k;
        logic [3:0]  a;
        logic [2:0]  f;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, w;
    } vec_t;

    task automatic test_directed();
        vec_t v [7] = '{
            '{3'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3},
            '{3'd0, 4'd1, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0,          32'h407302B3},
            '{3'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd7, 32'hFFFF_FFFF,  32'hFFF00093},
            '{3'd1, 4'd7, 3'd0, 5'd2, 5'd2, 5'd0, 32'd3,          32'h40315113},
            '{3'd3, 4'd0, 3'd2, 5'd9, 5'd2, 5'd5, 32'd8,          32'h00512423},
            '{3'd4, 4'd0, 3'd0, 5'd9, 5'd1, 5'd2, 32'd8,          32'h00208463},
            '{3'd5, 4'd0, 3'd0, 5'd0, 5'd0, 5'd7, 32'd0,          32'h0000006F}
        };
        wr_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(v[i].k, v[i].a, v[i].f, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            @(negedge clk);
            n_cmp++;
            if (wr_en !== 1'b1 || wr_data !== v[i].w || wr_addr !== BASE + 32'(4 * i)) begin
                n_bad++;
                $display("FAIL directed_%0d got en=%b data=%h addr=%h want en=1 data=%h addr=%h",
                         i, wr_en, wr_data, wr_addr, v[i].w, BASE + 32'(4 * i));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        bit          ok;
        bit          take;
        logic [31:0] w0;
        int          writes = 0;
        pulse_reset();
        wr_ready = 1'b0;
        ref_encode(1, 0, 0, 1, 1, 0, 1, ok, w0);
        for (int i = 1; i <= 4; i++) send(3'd1, 4'd0, 3'd0, 5'(i), 5'(i), 5'd0, 32'(i));
        in_kind = 3'd1; in_aluop = 4'd0; in_rd = 5'd5; in_rs1 = 5'd5; in_imm = 32'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || wr_en !== 1'b1 || wr_data !== w0 || wr_addr !== BASE) begin
                n_bad++;
                $display("FAIL bp_hold_%0d got rdy=%b en=%b data=%h addr=%h want 0 1 %h %h",
                         i, in_ready, wr_en, wr_data, wr_addr, w0, BASE);
            end
            @(posedge clk); #1;
        end
        wr_ready = 1'b1;
        for (int c = 0; c < 40 && (writes < 5 || in_valid); c++) begin
            @(negedge clk);
            take = in_valid && in_ready;
            if (wr_en === 1'b1) writes++;
            @(posedge clk); #1;
            if (take) in_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (writes != 5 || count !== 16'd5 || wr_en !== 1'b0 || wr_addr !== BASE + 32'd20) begin
            n_bad++;
            $display("FAIL bp_release got writes=%0d cnt=%0d en=%b addr=%h want 5 5 0 %h",
                     writes, count, wr_en, wr_addr, BASE + 32'd20);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        bit          ok;
        logic [31:0] w;
        wr_ready = 1'b1;
        send(3'd4, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        @(negedge clk);
        n_cmp++;
        if (wr_en !== 1'b0 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_branch_odd got en=%b err=%b want 0 1", wr_en, err);
        end
        @(posedge clk); #1;
        send(3'd1, 4'd1, 3'd0, 5'd4, 5'd4, 5'd0, 32'd0);
        @(negedge clk);
        n_cmp++;
        if (wr_en !== 1'b0 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_subi got en=%b err=%b want 0 1", wr_en, err);
        end
        @(posedge clk); #1;
        ref_encode(0, 0, 0, 7, 8, 9, 0, ok, w);
        send(3'd0, 4'd0, 3'd0, 5'd7, 5'd8, 5'd9, 32'd0);
        @(negedge clk);
        n_cmp++;
        if (wr_en !== 1'b1 || wr_data !== w || wr_addr !== BASE + 32'd20 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_then_legal got en=%b data=%h addr=%h err=%b want 1 %h %h 1",
                     wr_en, wr_data, wr_addr, err, w, BASE + 32'd20);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int edges [14] = '{-2048, 2047, 2048, -2049, 4094, 4095, -4096, -4098,
                           1048574, -1048576, 1048576, 31, 32, -1};
        int imm;
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    case ($urandom_range(0, 4))
                        0: imm = int'($urandom_range(0, 40)) - 4;
                        1: imm = int'($urandom_range(0, 8400)) - 4200;
                        2: imm = int'($urandom_range(0, 2200000)) - 1100000;
                        3: imm = int'($urandom);
                        default: imm = edges[$urandom_range(0, 13)];
                    endcase
                    send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 11)), 3'($urandom_range(0, 7)),
                         5'($urandom), 5'($urandom), 5'($urandom), 32'(imm));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    wr_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
    endtask

    task automatic test_wrap();
        bit          ok;
        logic [31:0] wa, wb;
        ref_encode(1, 0, 0, 1, 0, 0, 5, ok, wa);
        ref_encode(1, 0, 0, 2, 0, 0, 6, ok, wb);
        w_ready = 1'b0;
        in_kind = 3'd1; in_aluop = 4'd0; in_f3 = 3'd0; in_rd = 5'd1; in_rs1 = 5'd0;
        in_rs2 = 5'd0; in_imm = 32'd5;
        w_valid = 1'b1;
        @(posedge clk); #1;
        in_rd = 5'd2; in_imm = 32'd6;
        @(posedge clk); #1;
        w_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (w_en !== 1'b1 || w_addr !== 4'd12 || w_data !== wa) begin
            n_bad++;
            $display("FAIL wrap_first got en=%b addr=%0d data=%h want 1 12 %h", w_en, w_addr, w_data, wa);
        end
        @(posedge clk); #1;
        w_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (w_en !== 1'b1 || w_addr !== 4'd0 || w_data !== wb) begin
            n_bad++;
            $display("FAIL wrap_second got en=%b addr=%0d data=%h want 1 0 %h", w_en, w_addr, w_data, wb);
        end
        @(negedge clk);
        n_cmp++;
        if (w_en !== 1'b0 || w_addr !== 4'd4 || w_count !== 16'd2) begin
            n_bad++;
            $display("FAIL wrap_done got en=%b addr=%0d cnt=%0d want 0 4 2", w_en, w_addr, w_count);
        end
        @(posedge clk); #1;
        w_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(3'd6, 4'd0, 3'd0, 5'(i + 1), 5'd3, 5'd0, 32'(i * 16));
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_ready got=%b want 0", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wr_en !== 1'b0 || wr_addr !== BASE || wr_data !== 32'd0 || count !== 16'd0 ||
            err !== 1'b0 || in_ready !== 1'b1 || w_count !== 16'd0) begin
            n_bad++;
            $display("FAIL midreset_state got en=%b addr=%h data=%h cnt=%0d err=%b rdy=%b wcnt=%0d want 0 %h 0 0 0 1 0",
                     wr_en, wr_addr, wr_data, count, err, in_ready, w_count, BASE);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; wr_ready = 1'b0; w_valid = 1'b0; w_ready = 1'b0;
        in_kind = '0; in_aluop = '0; in_f3 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_illegal();
        test_random();
        test_wrap();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
